// File: rtl/debounce_pkg.sv
// debounce_pkg: shared FSM state encoding and default qualification length for input_debouncer
package debounce_pkg;
  localparam int unsigned STABLE_CYCLES_DEF = 4;
  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    CHECK_HIGH  = 2'd1,
    STABLE_HIGH = 2'd2,
    CHECK_LOW   = 2'd3
  } state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer bringing an asynchronous level into the clk domain
// ports: clk, sync_reset (sync, active-high, clears both flops), d (async in), q (synchronized out)
module sync_2ff (
  input  logic clk,
  input  logic sync_reset,
  input  logic d,
  output logic q
);
  logic r_meta;
  logic r_q;
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= d;
      r_q    <= r_meta;
    end
  end
  assign q = r_q;
endmodule

// File: rtl/input_debouncer.sv
// input_debouncer: synchronizes raw_in and accepts a new level only after STABLE_CYCLES agreeing samples
// ports: clk, sync_reset (sync, active-high), raw_in (async), enable (freezes FSM/counter when 0),
//        D_out (debounced level), rise_pulse/fall_pulse (one-cycle accept strobes), busy (qualifying)
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int unsigned CNT_W         = 8
) (
  input  logic clk,
  input  logic sync_reset,
  input  logic raw_in,
  input  logic enable,
  output logic D_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  logic             w_s;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_d_out, w_d_nxt;
  logic             r_rise, w_rise_nxt;
  logic             r_fall, w_fall_nxt;
  sync_2ff u_sync (
    .clk        (clk),
    .sync_reset (sync_reset),
    .d          (raw_in),
    .q          (w_s)
  );
  // cnt counts agreeing samples already seen; the sample that finds cnt==LAST is the last one needed
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_d_nxt     = r_d_out;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    if (enable) begin
      case (r_state)
        STABLE_LOW: begin
          w_state_nxt = w_s ? CHECK_HIGH : STABLE_LOW;
          w_cnt_nxt   = w_s ? ONE : '0;
        end
        CHECK_HIGH: begin
          if (!w_s) begin
            w_state_nxt = STABLE_LOW;
            w_cnt_nxt   = '0;
          end else if (r_cnt == LAST) begin
            w_state_nxt = STABLE_HIGH;
            w_cnt_nxt   = '0;
            w_d_nxt     = 1'b1;
            w_rise_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + ONE;
          end
        end
        STABLE_HIGH: begin
          w_state_nxt = w_s ? STABLE_HIGH : CHECK_LOW;
          w_cnt_nxt   = w_s ? '0 : ONE;
        end
        CHECK_LOW: begin
          if (w_s) begin
            w_state_nxt = STABLE_HIGH;
            w_cnt_nxt   = '0;
          end else if (r_cnt == LAST) begin
            w_state_nxt = STABLE_LOW;
            w_cnt_nxt   = '0;
            w_d_nxt     = 1'b0;
            w_fall_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + ONE;
          end
        end
        default: begin
          w_state_nxt = STABLE_LOW;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      r_state <= STABLE_LOW;
      r_cnt   <= '0;
      r_d_out <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_d_out <= w_d_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end
  assign D_out      = r_d_out;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
  assign busy       = (r_state == CHECK_HIGH) || (r_state == CHECK_LOW);
endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: directed timing checks plus randomized run against a run-length reference model
module tb_input_debouncer;
  localparam int STABLE = 4;
  logic clk = 1'b0;
  logic sync_reset = 1'b1;
  logic raw_in = 1'b0;
  logic enable = 1'b1;
  logic D_out, rise_pulse, fall_pulse, busy;
  int n_cmp = 0;
  int n_err = 0;
  int rel = 0;
  logic m_sync0 = 1'b0, m_sync1 = 1'b0, m_d = 1'b0, m_rise = 1'b0, m_fall = 1'b0;
  int m_run = 0;
  input_debouncer #(.STABLE_CYCLES(STABLE), .CNT_W(8)) dut (
    .clk        (clk),
    .sync_reset (sync_reset),
    .raw_in     (raw_in),
    .enable     (enable),
    .D_out      (D_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .busy       (busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic got, input logic exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s at rel edge %0d: got %b expected %b", tag, rel, got, exp);
    end
  endtask
  // model: a level is accepted once STABLE consecutive enabled samples of the synchronized input disagree with it
  task automatic model_edge(input logic raw, input logic en, input logic rst);
    logic s;
    if (rst) begin
      m_sync0 = 1'b0; m_sync1 = 1'b0; m_d = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_run = 0;
    end else begin
      s = m_sync1;
      m_sync1 = m_sync0;
      m_sync0 = raw;
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (en) begin
        if (s != m_d) begin
          m_run++;
          if (m_run == STABLE) begin
            m_d = s;
            m_rise = s;
            m_fall = !s;
            m_run = 0;
          end
        end else begin
          m_run = 0;
        end
      end
    end
  endtask
  task automatic step(input logic raw, input logic en, input logic rst);
    raw_in = raw;
    enable = en;
    sync_reset = rst;
    @(posedge clk);
    rel++;
    model_edge(raw, en, rst);
    #1;
    chk("d_out", D_out, m_d);
    chk("rise", rise_pulse, m_rise);
    chk("fall", fall_pulse, m_fall);
    chk("busy", busy, m_run != 0);
  endtask
  task automatic run(input logic raw, input int n);
    for (int i = 0; i < n; i++) step(raw, 1'b1, 1'b0);
  endtask
  task automatic start();
    rel = 0;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b1);
      chk("rst_d", D_out, 1'b0);
      chk("rst_rise", rise_pulse, 1'b0);
      chk("rst_fall", fall_pulse, 1'b0);
      chk("rst_busy", busy, 1'b0);
    end
    run(1'b0, 7);
  endtask
  initial begin
    int hold;
    logic lvl, en, rs;
    start();
    run(1'b1, 3);
    chk("a_busy12", busy, 1'b1);
    run(1'b1, 2);
    chk("a_d14", D_out, 1'b0);
    run(1'b1, 1);
    chk("a_d15", D_out, 1'b1);
    chk("a_rise15", rise_pulse, 1'b1);
    run(1'b1, 1);
    chk("a_rise16", rise_pulse, 1'b0);
    run(1'b1, 13);
    run(1'b0, 5);
    chk("a_d34", D_out, 1'b1);
    run(1'b0, 1);
    chk("a_d35", D_out, 1'b0);
    chk("a_fall35", fall_pulse, 1'b1);
    run(1'b0, 1);
    chk("a_fall36", fall_pulse, 1'b0);
    start();
    run(1'b1, 2);
    run(1'b0, 1);
    chk("b_busy12", busy, 1'b1);
    run(1'b0, 3);
    chk("b_busy15", busy, 1'b0);
    chk("b_d15", D_out, 1'b0);
    run(1'b0, 3);
    chk("b_d18", D_out, 1'b0);
    start();
    run(1'b1, 3);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    chk("c_busy15", busy, 1'b1);
    run(1'b1, 2);
    chk("c_d17", D_out, 1'b0);
    run(1'b1, 1);
    chk("c_d18", D_out, 1'b1);
    chk("c_rise18", rise_pulse, 1'b1);
    run(1'b1, 1);
    chk("c_rise19", rise_pulse, 1'b0);
    start();
    run(1'b1, 3);
    step(1'b1, 1'b1, 1'b1);
    chk("d_busy13", busy, 1'b0);
    chk("d_d13", D_out, 1'b0);
    run(1'b1, 5);
    chk("d_d18", D_out, 1'b0);
    run(1'b1, 1);
    chk("d_d19", D_out, 1'b1);
    chk("d_rise19", rise_pulse, 1'b1);
    hold = 0;
    lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        lvl = 1'(~lvl);
        hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 12)) : int'($urandom_range(1, 5));
      end
      hold--;
      en = ($urandom_range(0, 7) != 0);
      rs = ($urandom_range(0, 199) == 0);
      step(lvl, en, rs);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
